prefix_sum_stage: RTL and testbench
===================================

Name: prefix_sum_stage

Overview:
Final, registered stage of the 32-bit parallel-prefix adder. It sits directly after the last prefix layer and takes the resolved group-generate (carry) vector, the per-bit half-sum (p = a ^ b) and carry-in. It forms sum, carry-out and status flags, and registers them behind a valid/ready handshake. A 2-entry skid buffer decouples the adder datapath from the ALU writeback, so the adder can be pipelined without combinational ready paths.

Parameters:
WIDTH, 32, datapath width; the prefix tree is built for 32, and other values are for bench reuse only.
TAGW, 4, width of the opaque tag carried alongside each operation.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream presents a valid operation this cycle
in_ready  out  1  stage can accept; transfer occurs when in_valid & in_ready
p  in  WIDTH  half-sum bits a[i]^b[i]
gc  in  WIDTH  final prefix generate; gc[i] = carry out of bit i including c0
c0  in  1  carry-in of bit 0
tag_in  in  TAGW  opaque tag, returned unchanged with the result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts; transfer occurs when out_valid & out_ready
sum  out  WIDTH  result
cout  out  1  unsigned carry-out
ovf  out  1  signed overflow
zero  out  1  sum == 0
neg  out  1  sum[WIDTH-1]
tag_out  out  TAGW  tag of the presented result

Behaviour:
- Arithmetic is combinational before the registers:
  - carry vector c = {gc[WIDTH-2:0], c0}
  - sum = p ^ c
  - cout = gc[WIDTH-1]
  - ovf = gc[WIDTH-1] ^ gc[WIDTH-2]
  - zero = ~|sum
  - neg = sum[WIDTH-1]
- Storage: an output register (main) plus one skid register (skid). Each holds {sum, cout, ovf, zero, neg, tag} and a valid bit.
- Output ports are driven only from main; no combinational path from p/gc to the outputs.
- Latency: an accepted input appears on the outputs exactly 1 cycle later when main is empty or draining.
- in_ready is registered and equals ~skid_valid. It never depends combinationally on out_ready.
- Per-cycle rules, with acc = in_valid & in_ready and drn = out_valid & out_ready:
  - main empty, acc: load main.
  - main full, drn, skid empty, acc: load main with new data.
  - main full, drn, skid full: move skid to main, clear skid; acc is impossible because in_ready is 0.
  - main full, no drn, acc: load skid, and in_ready drops next cycle.
  - main full, drn, no acc, skid empty: main becomes empty and out_valid goes to 0.
- Ordering: results leave strictly in acceptance order; tag_out must match tag_in order.
- Hold: while out_valid=1 and out_ready=0, all output ports stay stable.
- Reset, synchronous, takes priority over any transfer in the same cycle:
  - out_valid=0, skid_valid=0, in_ready=1.
  - sum=0, cout=0, ovf=0, zero=0, neg=0, tag_out=0.
  - Reset mid-operation discards both held entries; nothing is emitted afterwards.
- in_valid while in_ready=0 is not a transfer. Upstream must hold its data; the stage ignores it.
- Throughput: 1 operation/cycle sustained while out_ready=1.

Test Plan:
- Wrap: p=0xFFFFFFFE, gc=0xFFFFFFFF, c0=0 (0xFFFFFFFF+1), out_ready=1 -> one cycle later: sum=0x00000000, cout=1, ovf=0, zero=1, neg=0.
- Signed overflow: p=0x7FFFFFFE, gc=0x7FFFFFFF, c0=0 (0x7FFFFFFF+1) -> sum=0x80000000, cout=0, ovf=1, neg=1, zero=0.
- Carry-in only: p=0, gc=0, c0=1 -> sum=0x00000001, all flags 0. Subtract case 5-5 as p=0xFFFFFFFF, gc=0xFFFFFFFF, c0=1 -> sum=0, cout=1, zero=1.
- Backpressure: stream tags 1,2,3 with out_ready=0.
  - Tag 1 lands in main, tag 2 in skid, and in_ready=0 the following cycle; tag 3 is held off.
  - Raise out_ready: tags emerge 1,2,3 in order with no loss and no duplication.
  - Outputs stay stable while stalled.
- Throughput: 16 back-to-back random operations with out_ready=1 -> 16 results on consecutive cycles, each 1 cycle after its input, matching a+b+c0 from the bench model.
- Reset mid-stall: main and skid full, assert rst for 1 cycle -> next cycle out_valid=0, in_ready=1, sum=0, tag_out=0; the two held results are never emitted.

Source files
------------

// File: rtl/prefix_sum_stage.sv
// Final registered stage of the 32-bit parallel-prefix adder: forms sum and flags
// from the resolved carries, then holds results in a main register backed by one skid entry.
module prefix_sum_stage #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] gc,
  input  logic             c0,
  input  logic [TAGW-1:0]  tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic [TAGW-1:0]  tag_out
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // in_ready is a register (~skid_valid) so it never depends on out_ready.
  localparam int DW = WIDTH + 4 + TAGW;

  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_zero;
  logic             w_neg;
  logic [DW-1:0]    w_new;
  logic             w_acc;
  logic             w_drn;

  logic [DW-1:0]    r_main;
  logic [DW-1:0]    r_skid;
  logic             r_main_valid;
  logic             r_skid_valid;
  logic             r_in_ready;

  // Carry into bit i is the prefix generate out of bit i-1; bit 0 takes c0.
  assign w_carry = {gc[WIDTH-2:0], c0};
  assign w_sum   = p ^ w_carry;
  assign w_cout  = gc[WIDTH-1];
  assign w_ovf   = gc[WIDTH-1] ^ gc[WIDTH-2];
  assign w_zero  = ~|w_sum;
  assign w_neg   = w_sum[WIDTH-1];
  assign w_new   = {w_sum, w_cout, w_ovf, w_zero, w_neg, tag_in};

  assign w_acc = in_valid & r_in_ready;
  assign w_drn = r_main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (!r_main_valid || w_drn) begin
      // Main is free this cycle; the skid entry is older than any new input.
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_acc) begin
        r_main       <= w_new;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign sum       = r_main[DW-1 -: WIDTH];
  assign cout      = r_main[TAGW+3];
  assign ovf       = r_main[TAGW+2];
  assign zero      = r_main[TAGW+1];
  assign neg       = r_main[TAGW];
  assign tag_out   = r_main[TAGW-1:0];

endmodule

// File: tb/tb_prefix_sum_stage.sv
// Bench for prefix_sum_stage: drives a, b, c0 as p/gc through a ripple carry model
// and checks results against a + b + c0 via an expected queue.
module tb_prefix_sum_stage;

  localparam int WIDTH = 32;
  localparam int TAGW  = 4;
  localparam int DW    = WIDTH + 4 + TAGW;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] gc;
  logic             c0;
  logic [TAGW-1:0]  tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;
  logic [TAGW-1:0]  tag_out;

  prefix_sum_stage #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p(p), .gc(gc), .c0(c0), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg), .tag_out(tag_out)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int            cyc_q[$];
  logic [WIDTH-1:0] cur_a;
  logic [WIDTH-1:0] cur_b;
  logic             cur_ci;
  bit               check_lat = 1'b0;
  int               lat_outs  = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ripple_gc(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b, input logic ci);
    logic c;
    logic [WIDTH-1:0] g;
    c = ci;
    for (int i = 0; i < WIDTH; i++) begin
      c    = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      g[i] = c;
    end
    return g;
  endfunction

  function automatic logic [DW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic ci, input logic [TAGW-1:0] t);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] s;
    logic             v;
    full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    s    = full[WIDTH-1:0];
    v    = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    return {s, full[WIDTH], v, (s == '0), s[WIDTH-1], t};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ci, input logic [TAGW-1:0] t);
    cur_a    = a;
    cur_b    = b;
    cur_ci   = ci;
    p        = a ^ b;
    gc       = ripple_gc(a, b, ci);
    c0       = ci;
    tag_in   = t;
    in_valid = 1'b1;
  endtask

  // Scoreboard: compare outputs that transfer, then record accepted inputs
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_valid), 64'(1'b0));
      end else begin
        logic [DW-1:0] e;
        int            c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("result", 64'({sum, cout, ovf, zero, neg, tag_out}), 64'(e));
        if (check_lat) begin
          check("latency", 64'(cyc - c), 64'd1);
          lat_outs++;
        end
      end
    end
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model(cur_a, cur_b, cur_ci, tag_in));
      cyc_q.push_back(cyc);
    end
  end

  logic [DW-1:0] snap;
  int            n;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    p = '0; gc = '0; c0 = 1'b0; tag_in = '0;
    cur_a = '0; cur_b = '0; cur_ci = 1'b0;
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_outputs", 64'({sum, cout, ovf, zero, neg, tag_out}), 64'd0);
    rst = 1'b0;
    step();

    // Directed arithmetic corners, back to back
    out_ready = 1'b1;
    check_lat = 1'b1;
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'h1);
    check("wrap_p", 64'(p), 64'hFFFF_FFFE);
    check("wrap_gc", 64'(gc), 64'hFFFF_FFFF);
    step();
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'h2);
    step();
    drive(32'h0, 32'h0, 1'b1, 4'h3);
    step();
    drive(32'h5, ~32'h5, 1'b1, 4'h4);
    step();
    in_valid = 1'b0;
    step(); step();
    check("directed_drained", 64'(exp_q.size()), 64'd0);
    check_lat = 1'b0;

    // Backpressure: tag 1 to main, tag 2 to skid, tag 3 held off
    out_ready = 1'b0;
    drive(32'd10, 32'd1, 1'b0, 4'h1);
    step();
    check("bp_main_valid", 64'(out_valid), 64'd1);
    check("bp_main_tag", 64'(tag_out), 64'd1);
    drive(32'd20, 32'd2, 1'b0, 4'h2);
    step();
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    drive(32'd30, 32'd3, 1'b1, 4'h3);
    snap = {sum, cout, ovf, zero, neg, tag_out};
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold", 64'({sum, cout, ovf, zero, neg, tag_out}), 64'(snap));
      check("bp_still_blocked", 64'(in_ready), 64'd0);
    end
    check("bp_queue_two", 64'(exp_q.size()), 64'd2);
    out_ready = 1'b1;
    n = 0;
    step();
    while (!in_ready && n < 10) begin
      step();
      n++;
    end
    check("bp_ready_timeout", 64'(n < 10), 64'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    check("bp_idle", 64'(out_valid), 64'd0);

    // Throughput: 16 random operations on consecutive cycles
    check_lat = 1'b1;
    lat_outs  = 0;
    for (int i = 0; i < 16; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      step();
    end
    in_valid = 1'b0;
    step(); step();
    check("tp_count", 64'(lat_outs), 64'd16);
    check_lat = 1'b0;

    // Reset mid-stall discards both held results
    out_ready = 1'b0;
    drive(32'h1234, 32'h1, 1'b0, 4'h9);
    step();
    drive(32'h5678, 32'h2, 1'b0, 4'hA);
    step();
    in_valid = 1'b0;
    check("rs_full_valid", 64'(out_valid), 64'd1);
    check("rs_full_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    exp_q.delete();
    cyc_q.delete();
    step();
    rst = 1'b0;
    check("rs_out_valid", 64'(out_valid), 64'd0);
    check("rs_in_ready", 64'(in_ready), 64'd1);
    check("rs_sum", 64'(sum), 64'd0);
    check("rs_tag", 64'(tag_out), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rs_no_emit", 64'(out_valid), 64'd0);
    end
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
